// File: rtl/core_freq_meter.sv
// Gated frequency counter: counts synchronised rising edges of sig_in over
// back-to-back windows of GATE_CYCLES clocks and latches each completed count.
module core_freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow,
  output logic             gate_active
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic             prev;
  logic             edge_det;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_final;
  logic             sat;
  logic             sat_final;
  logic             window_done;
  logic             abort;

  // Synchroniser and prev run in every state so a level already high at
  // window start never registers as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync[SYNC_STAGES-1] & ~prev;

  always_comb begin
    edge_final = edge_cnt;
    sat_final  = sat;
    if (edge_det) begin
      if (edge_cnt == '1) sat_final  = 1'b1;
      else                edge_final = edge_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    window_done = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = MEASURE;
      end
      MEASURE: begin
        if (!enable) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (gate_cnt == GATE_LAST) begin
          window_done = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign gate_active = (state == MEASURE);

  // Completion clears the counters and the next window starts on the
  // following cycle, so every clock belongs to exactly one window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq_out   <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
    end else begin
      freq_valid <= window_done;
      if (state == IDLE || abort) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end else if (window_done) begin
        freq_out <= edge_final;
        overflow <= sat_final;
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
      end else begin
        gate_cnt <= gate_cnt + GW'(1);
        edge_cnt <= edge_final;
        sat      <= sat_final;
      end
    end
  end

endmodule

// File: tb/tb_core_freq_meter.sv
// Directed bench for core_freq_meter: a 24-bit instance and a 4-bit instance
// (saturation cases) share clock, reset, enable and the stimulus signal.
module tb_core_freq_meter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sig_in = 1'b0;
  logic [23:0] freq_a;
  logic        fv_a, ov_a, ga_a;
  logic [3:0]  freq_b;
  logic        fv_b, ov_b, ga_b;

  int sig_period = 10;
  logic sig_level = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_freq_meter #(.GATE_CYCLES(100), .CNT_W(24), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .freq_out(freq_a), .freq_valid(fv_a), .overflow(ov_a), .gate_active(ga_a)
  );

  core_freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .freq_out(freq_b), .freq_valid(fv_b), .overflow(ov_b), .gate_active(ga_b)
  );

  // Stimulus generator: square wave of sig_period clocks, or a held level.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(negedge clk);
      phase++;
      if (sig_period == 0) sig_in = sig_level;
      else                 sig_in = ((phase % sig_period) < (sig_period / 2));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge where freq_valid is high; bounded.
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fv_a !== 1'b1 && n < 300);
    check({tag, "_timeout"}, 32'(fv_a), 32'd1);
  endtask

  initial begin
    int n;
    int pulses;
    logic [23:0] held;

    // Reset state
    #1;
    check("rst_freq", 32'(freq_a), 32'd0);
    check("rst_valid", 32'(fv_a), 32'd0);
    check("rst_ovf", 32'(ov_a), 32'd0);
    check("rst_gate", 32'(ga_a), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_gate", 32'(ga_a), 32'd0);

    // Period 10: first window after enable entry starts 1 cycle later
    enable = 1'b1;
    @(negedge clk);
    check("gate_rise", 32'(ga_a), 32'd1);
    wait_valid("p10_w0", n);
    check("p10_first_latency", 32'(n), 32'd100);
    wait_valid("p10_w1", n);
    check("p10_interval", 32'(n), 32'd100);
    check("p10_freq", 32'(freq_a), 32'd10);
    check("p10_ovf", 32'(ov_a), 32'd0);
    check("p10_b_freq", 32'(freq_b), 32'd10);
    check("p10_b_valid", 32'(fv_b), 32'd1);
    check("p10_gate", 32'(ga_a), 32'd1);
    @(negedge clk);
    check("p10_valid_pulse", 32'(fv_a), 32'd0);
    check("p10_gate_between", 32'(ga_a), 32'd1);

    // Abort at gate_cnt=50: the cycle after the valid pulse held gate_cnt=1
    repeat (49) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_gate", 32'(ga_a), 32'd0);
    held = freq_a;
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (fv_a === 1'b1) pulses++;
    end
    check("abort_no_valid", 32'(pulses), 32'd0);
    check("abort_freq_held", 32'(freq_a), 32'd10);
    check("abort_freq_same", 32'(held), 32'd10);
    enable = 1'b1;
    @(negedge clk);
    check("reen_gate", 32'(ga_a), 32'd1);
    wait_valid("reen", n);
    check("reen_latency", 32'(n), 32'd100);
    check("reen_freq", 32'(freq_a), 32'd10);

    // Held low, then held high
    sig_period = 0;
    sig_level = 1'b0;
    wait_valid("low_skip", n);
    wait_valid("low", n);
    check("low_freq", 32'(freq_a), 32'd0);
    sig_level = 1'b1;
    wait_valid("high_skip", n);
    wait_valid("high", n);
    check("high_freq", 32'(freq_a), 32'd0);
    wait_valid("high2", n);
    check("high_freq2", 32'(freq_a), 32'd0);

    // Max rate: period 2
    sig_period = 2;
    wait_valid("p2_skip", n);
    wait_valid("p2", n);
    check("p2_freq", 32'(freq_a), 32'd50);
    check("p2_ovf", 32'(ov_a), 32'd0);
    check("p2_b_freq", 32'(freq_b), 32'd15);
    check("p2_b_ovf", 32'(ov_b), 32'd1);

    // Period 4: 25 edges saturate the 4-bit counter
    sig_period = 4;
    wait_valid("p4_skip", n);
    wait_valid("p4", n);
    check("p4_freq", 32'(freq_a), 32'd25);
    check("p4_b_freq", 32'(freq_b), 32'd15);
    check("p4_b_ovf", 32'(ov_b), 32'd1);
    sig_period = 0;
    sig_level = 1'b0;
    wait_valid("idle_skip", n);
    wait_valid("idle", n);
    check("idle_b_freq", 32'(freq_b), 32'd0);
    check("idle_b_ovf", 32'(ov_b), 32'd0);
    check("idle_a_freq", 32'(freq_a), 32'd0);

    // Asynchronous reset mid-window
    sig_period = 10;
    wait_valid("rst_skip0", n);
    wait_valid("rst_pre", n);
    check("rst_pre_freq", 32'(freq_a), 32'd10);
    sig_period = 3;
    wait_valid("rst_pre3", n);
    check("p3_b_ovf", 32'(ov_b), 32'd1);
    repeat (30) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_freq", 32'(freq_a), 32'd0);
    check("arst_ovf_b", 32'(ov_b), 32'd0);
    check("arst_valid", 32'(fv_a), 32'd0);
    check("arst_gate", 32'(ga_a), 32'd0);
    sig_period = 10;
    @(negedge clk);
    reset_n = 1'b1;
    wait_valid("post_skip", n);
    wait_valid("post", n);
    check("post_freq", 32'(freq_a), 32'd10);
    check("post_ovf", 32'(ov_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
